// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-flow sequencer for the 8-bit program counter.
// Each cycle it picks one of increment, jump, call, return, hold or
// fault-vector load. It drives the counter's load enable and load value,
// owns a LIFO return-address stack, and runs the BOOT/RUN/HALT/FAULT state
// machine. The counter has no reset of its own, so this block also supplies
// the boot address.
//
// Optional feature macro: PC_CTRL_IRQ_EN (adds level interrupt entry/return).
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     synchronous reset, active low
//   pc_i       current program counter value
//   target_i   jump/call target address
//   jmp_i      jump request, qualified by cond_i
//   cond_i     000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 !C, 111 never
//   z_i/n_i/c_i ALU flags
//   call_i     push pc_i+1 and load target_i
//   ret_i      pop return address and load it
//   halt_i     request halt
//   resume_i   leave halt
//   irq_i      level interrupt request        (PC_CTRL_IRQ_EN only)
//   reti_i     return from interrupt          (PC_CTRL_IRQ_EN only)
//   irq_ack_o  interrupt taken this cycle     (PC_CTRL_IRQ_EN only)
//   load_o     program counter load enable (combinational)
//   im_o       program counter load value (combinational)
//   state_o    00 BOOT, 01 RUN, 10 HALT, 11 FAULT
//   sp_o       stack occupancy
//   fault_o    high while in FAULT
module pc_seq_ctrl #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [7:0]  RESET_VEC   = 8'h00,
  parameter logic [7:0]  FAULT_VEC   = 8'hFF,
  parameter logic [7:0]  IRQ_VEC     = 8'h80,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [7:0]      pc_i,
  input  logic [7:0]      target_i,
  input  logic            jmp_i,
  input  logic [2:0]      cond_i,
  input  logic            z_i,
  input  logic            n_i,
  input  logic            c_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic            halt_i,
  input  logic            resume_i,
`ifdef PC_CTRL_IRQ_EN
  input  logic            irq_i,
  input  logic            reti_i,
  output logic            irq_ack_o,
`endif
  output logic            load_o,
  output logic [7:0]      im_o,
  output logic [1:0]      state_o,
  output logic [SP_W-1:0] sp_o,
  output logic            fault_o
);

  localparam logic [1:0] S_BOOT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_HALT  = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  logic [1:0]      state, state_nxt;
  logic [SP_W-1:0] sp, sp_nxt;
  logic [7:0]      stack [STACK_DEPTH];
  logic [7:0]      top;
  logic            push;
  logic [7:0]      push_val;
  logic            cond_ok;
  logic            full;
  logic            ret_req;
  logic            ret_bad;
  logic            irq_take;
  logic            irq_go;
  logic            reti_go;

`ifdef PC_CTRL_IRQ_EN
  logic in_isr;

  // reti is a plain return that also leaves the ISR; outside an ISR it faults
  assign ret_req  = ret_i | reti_i;
  assign ret_bad  = reti_i & ~in_isr;
  assign irq_take = irq_i & ~in_isr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      in_isr <= 1'b0;
    end else if (irq_go) begin
      in_isr <= 1'b1;
    end else if (reti_go) begin
      in_isr <= 1'b0;
    end
  end

  assign irq_ack_o = irq_go;
`else
  logic unused_isr;

  assign ret_req    = ret_i;
  assign ret_bad    = 1'b0;
  assign irq_take   = 1'b0;
  assign unused_isr = irq_go ^ reti_go;
`endif

  assign full = (sp == SP_W'(STACK_DEPTH));

  always_comb begin
    cond_ok = 1'b0;
    case (cond_i)
      3'b000:  cond_ok = 1'b1;
      3'b001:  cond_ok = z_i;
      3'b010:  cond_ok = ~z_i;
      3'b011:  cond_ok = n_i;
      3'b100:  cond_ok = ~n_i;
      3'b101:  cond_ok = c_i;
      3'b110:  cond_ok = ~c_i;
      default: cond_ok = 1'b0;
    endcase
  end

  // Top-of-stack read by comparison so the index never needs a width cast
  // that breaks for a single-entry stack.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (SP_W'(i + 1) == sp) top = stack[i];
    end
  end

  always_comb begin
    load_o    = 1'b1;
    im_o      = RESET_VEC;
    state_nxt = state;
    sp_nxt    = sp;
    push      = 1'b0;
    push_val  = pc_i + 8'd1;
    irq_go    = 1'b0;
    reti_go   = 1'b0;

    case (state)
      S_BOOT: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (ret_req) begin
          if (sp == '0 || ret_bad) begin
            im_o      = FAULT_VEC;
            state_nxt = S_FAULT;
          end else begin
            im_o    = top;
            sp_nxt  = sp - SP_W'(1);
            reti_go = 1'b1;
          end
        end else if (call_i) begin
          if (full) begin
            im_o      = FAULT_VEC;
            state_nxt = S_FAULT;
          end else begin
            im_o   = target_i;
            push   = 1'b1;
            sp_nxt = sp + SP_W'(1);
          end
        end else if (irq_take) begin
          if (full) begin
            im_o      = FAULT_VEC;
            state_nxt = S_FAULT;
          end else begin
            // the instruction at pc_i is pre-empted, so it is re-executed on return
            im_o     = IRQ_VEC;
            push     = 1'b1;
            push_val = pc_i;
            sp_nxt   = sp + SP_W'(1);
            irq_go   = 1'b1;
          end
        end else if (jmp_i && cond_ok) begin
          im_o = target_i;
        end else if (halt_i) begin
          im_o      = pc_i;
          state_nxt = S_HALT;
        end else begin
          load_o = 1'b0;
          im_o   = target_i;
        end
      end
      S_HALT: begin
        im_o = pc_i;
        if (resume_i) state_nxt = S_RUN;
      end
      default: begin
        im_o = FAULT_VEC;
      end
    endcase

    if (!rst_ni) begin
      load_o  = 1'b1;
      im_o    = RESET_VEC;
      push    = 1'b0;
      irq_go  = 1'b0;
      reti_go = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= S_BOOT;
      sp    <= '0;
    end else begin
      state <= state_nxt;
      sp    <= sp_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (push && SP_W'(i) == sp) stack[i] <= push_val;
    end
  end

  assign state_o = state;
  assign sp_o    = sp;
  assign fault_o = (state == S_FAULT);

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: scoreboard bench for pc_seq_ctrl. Each driven cycle pushes
// its expected load/im/state/sp; a checker pops and compares mid-cycle.
// A small program counter model follows load_o/im_o when counter mode is on.
module tb_pc_seq_ctrl;

  localparam logic [1:0] BOOT  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] HALT  = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pc, pc_cnt, pc_drv;
  logic       use_cnt;
  logic [7:0] target;
  logic       jmp, call, ret, halt, resume;
  logic [2:0] cond;
  logic       z, n, c;
  logic       load;
  logic [7:0] im;
  logic [1:0] state;
  logic [2:0] sp;
  logic       fault;
`ifdef PC_CTRL_IRQ_EN
  logic       irq, reti, ack;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic       ld;
    logic [7:0] im;
    bit         im_care;
    logic [1:0] st;
    int         sp;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  pc_seq_ctrl #(.STACK_DEPTH(4), .RESET_VEC(8'h00), .FAULT_VEC(8'hFF), .IRQ_VEC(8'h80)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .pc_i     (pc),
    .target_i (target),
    .jmp_i    (jmp),
    .cond_i   (cond),
    .z_i      (z),
    .n_i      (n),
    .c_i      (c),
    .call_i   (call),
    .ret_i    (ret),
    .halt_i   (halt),
    .resume_i (resume),
`ifdef PC_CTRL_IRQ_EN
    .irq_i    (irq),
    .reti_i   (reti),
    .irq_ack_o(ack),
`endif
    .load_o   (load),
    .im_o     (im),
    .state_o  (state),
    .sp_o     (sp),
    .fault_o  (fault)
  );

  always #5 clk = ~clk;

  assign pc = use_cnt ? pc_cnt : pc_drv;

  // program counter model: load or increment on each rising edge
  always @(posedge clk) pc_cnt <= load ? im : pc_cnt + 8'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_true(input logic [2:0] cd, input logic fz, input logic fn, input logic fc);
    case (cd)
      3'd0:    return 1'b1;
      3'd1:    return fz;
      3'd2:    return !fz;
      3'd3:    return fn;
      3'd4:    return !fn;
      3'd5:    return fc;
      3'd6:    return !fc;
      default: return 1'b0;
    endcase
  endfunction

  // one cycle of stimulus: inputs already set, expectation queued
  task automatic cyc(input string tag, input logic ld, input logic [7:0] eim, input bit care,
                     input logic [1:0] st, input int esp, input logic eack = 1'b0);
    exp_t x;
    x.tag = tag; x.ld = ld; x.im = eim; x.im_care = care; x.st = st; x.sp = esp; x.ack = eack;
    sb.push_back(x);
    @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #3;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".load"}, 32'(load), 32'(e.ld));
      if (e.im_care) check({e.tag, ".im"}, 32'(im), 32'(e.im));
      check({e.tag, ".state"}, 32'(state), 32'(e.st));
      check({e.tag, ".sp"}, 32'(sp), 32'(e.sp));
      check({e.tag, ".fault"}, 32'(fault), 32'(e.st == FAULT));
`ifdef PC_CTRL_IRQ_EN
      check({e.tag, ".ack"}, 32'(ack), 32'(e.ack));
`endif
    end
  end

  initial begin
    rst_n = 1'b0; use_cnt = 1'b1; pc_drv = 8'h00; target = 8'h00;
    jmp = 0; call = 0; ret = 0; halt = 0; resume = 0; cond = 3'd0; z = 0; n = 0; c = 0;
`ifdef PC_CTRL_IRQ_EN
    irq = 0; reti = 0;
`endif
    @(negedge clk);

    // boot: three reset edges, one BOOT cycle, then the counter increments
    cyc("rst", 1, 8'h00, 1, BOOT, 0);
    cyc("rst", 1, 8'h00, 1, BOOT, 0);
    rst_n = 1'b1;
    cyc("boot", 1, 8'h00, 1, BOOT, 0);
    check("pc0", 32'(pc_cnt), 32'h00);
    cyc("inc", 0, 8'h00, 0, RUN, 0);
    check("pc1", 32'(pc_cnt), 32'h01);
    cyc("inc", 0, 8'h00, 0, RUN, 0);
    check("pc2", 32'(pc_cnt), 32'h02);

    // conditional jumps
    use_cnt = 1'b0; pc_drv = 8'h10; target = 8'h40; jmp = 1; cond = 3'b001; z = 1;
    cyc("jz_t", 1, 8'h40, 1, RUN, 0);
    z = 0;
    cyc("jz_f", 0, 8'h00, 0, RUN, 0);
    for (int cd = 0; cd < 8; cd++) begin
      for (int f = 0; f < 8; f++) begin
        logic [2:0] fl;
        fl = 3'(f);
        cond = 3'(cd); z = fl[0]; n = fl[1]; c = fl[2]; target = 8'(8'h60 + f);
        if (cond_true(cond, z, n, c)) cyc("jcond", 1, target, 1, RUN, 0);
        else cyc("jcond", 0, 8'h00, 0, RUN, 0);
      end
    end
    jmp = 0; z = 0; n = 0; c = 0; cond = 3'd0;

    // call/return nesting, including pc FF wrapping to 00
    call = 1; target = 8'hA0;
    pc_drv = 8'h05; cyc("call1", 1, 8'hA0, 1, RUN, 0);
    pc_drv = 8'h21; cyc("call2", 1, 8'hA0, 1, RUN, 1);
    pc_drv = 8'hFF; cyc("call3", 1, 8'hA0, 1, RUN, 2);
    call = 0; ret = 1;
    cyc("ret1", 1, 8'h00, 1, RUN, 3);
    cyc("ret2", 1, 8'h22, 1, RUN, 2);
    cyc("ret3", 1, 8'h06, 1, RUN, 1);
    ret = 0;
    cyc("idle", 0, 8'h00, 0, RUN, 0);

    // overflow on the fifth call, then FAULT is sticky with sp frozen
    call = 1; target = 8'h60; pc_drv = 8'h10;
    for (int i = 0; i < 4; i++) cyc("callf", 1, 8'h60, 1, RUN, i);
    cyc("ovf", 1, 8'hFF, 1, RUN, 4);
    cyc("flt", 1, 8'hFF, 1, FAULT, 4);
    call = 0; ret = 1; jmp = 1; halt = 1;
    cyc("flt", 1, 8'hFF, 1, FAULT, 4);
    jmp = 0; halt = 0;
    cyc("flt", 1, 8'hFF, 1, FAULT, 4);

    // reset out of FAULT; ret held through BOOT is ignored, then underflows
    rst_n = 0;
    cyc("rstf", 1, 8'h00, 1, FAULT, 4);
    rst_n = 1;
    cyc("boot2", 1, 8'h00, 1, BOOT, 0);
    cyc("unf", 1, 8'hFF, 1, RUN, 0);
    ret = 0;
    cyc("flt2", 1, 8'hFF, 1, FAULT, 0);
    rst_n = 0;
    cyc("rstf2", 1, 8'h00, 1, FAULT, 0);
    rst_n = 1;
    cyc("boot3", 1, 8'h00, 1, BOOT, 0);

    // halt with the counter model in the loop
    use_cnt = 1; jmp = 1; cond = 3'd0; target = 8'h33;
    cyc("j33", 1, 8'h33, 1, RUN, 0);
    jmp = 0; halt = 1;
    cyc("halt", 1, 8'h33, 1, RUN, 0);
    halt = 0; jmp = 1; target = 8'h77; call = 1; ret = 1;
    for (int i = 0; i < 5; i++) cyc("hold", 1, 8'h33, 1, HALT, 0);
    jmp = 0; call = 0; ret = 0; resume = 1;
    cyc("resume", 1, 8'h33, 1, HALT, 0);
    resume = 0;
    check("pc33", 32'(pc_cnt), 32'h33);
    cyc("run", 0, 8'h00, 0, RUN, 0);
    check("pc34", 32'(pc_cnt), 32'h34);

    // reset while halted
    halt = 1;
    cyc("halt2", 1, 8'h34, 1, RUN, 0);
    halt = 0; rst_n = 0;
    cyc("rsth", 1, 8'h00, 1, HALT, 0);
    rst_n = 1;
    cyc("boot4", 1, 8'h00, 1, BOOT, 0);

    // simultaneous ret+call+jmp with one entry: pop wins, no push
    use_cnt = 0; pc_drv = 8'h40; call = 1; target = 8'h90;
    cyc("callx", 1, 8'h90, 1, RUN, 0);
    ret = 1; jmp = 1;
    cyc("pri", 1, 8'h41, 1, RUN, 1);
    ret = 0; call = 0; jmp = 0;
    cyc("after", 0, 8'h00, 0, RUN, 0);

`ifdef PC_CTRL_IRQ_EN
    irq = 1; pc_drv = 8'h50;
    cyc("irq", 1, 8'h80, 1, RUN, 0, 1);
    pc_drv = 8'h80;
    cyc("isr", 0, 8'h00, 0, RUN, 1, 0);
    irq = 0; reti = 1;
    cyc("reti", 1, 8'h50, 1, RUN, 1, 0);
    cyc("reti_bad", 1, 8'hFF, 1, RUN, 0, 0);
    reti = 0;
    cyc("flt3", 1, 8'hFF, 1, FAULT, 0, 0);
`endif

    @(negedge clk);
    #5;
    check("drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
